// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU. Each port has a
// one-entry result slot; reset deassertion is expected to arrive synchronised to i_clk.
module alu_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [OP_WIDTH-1:0]   i_req0_op,
  input  logic [WORD_WIDTH-1:0] i_req0_in_0,
  input  logic [WORD_WIDTH-1:0] i_req0_in_1,
  output logic                  o_rsp0_valid,
  input  logic                  i_rsp0_ready,
  output logic [WORD_WIDTH-1:0] o_rsp0_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [OP_WIDTH-1:0]   i_req1_op,
  input  logic [WORD_WIDTH-1:0] i_req1_in_0,
  input  logic [WORD_WIDTH-1:0] i_req1_in_1,
  output logic                  o_rsp1_valid,
  input  logic                  i_rsp1_ready,
  output logic [WORD_WIDTH-1:0] o_rsp1_data,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic [WORD_WIDTH-1:0] o_alu_in_0,
  output logic [WORD_WIDTH-1:0] o_alu_in_1,
  input  logic [WORD_WIDTH-1:0] i_alu_out
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic                  r_lastGrant;
  logic [3:0]            r_waitCnt;
  logic                  r_rsp0Valid;
  logic                  r_rsp1Valid;
  logic [WORD_WIDTH-1:0] r_rsp0Data;
  logic [WORD_WIDTH-1:0] r_rsp1Data;

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;

  // A port is eligible only if its slot is empty or being drained this cycle
  assign w_elig0 = i_rst_n & i_req0_valid & (!r_rsp0Valid | i_rsp0_ready);
  assign w_elig1 = i_rst_n & i_req1_valid & (!r_rsp1Valid | i_rsp1_ready);

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_elig0 && w_elig1) begin
      if (FIXED_PRIO == 0) begin
        w_grant0 = r_lastGrant;
        w_grant1 = !r_lastGrant;
      end else if (r_waitCnt == MaxWait) begin
        w_grant1 = 1'b1;
      end else begin
        w_grant0 = 1'b1;
      end
    end else begin
      w_grant0 = w_elig0;
      w_grant1 = w_elig1;
    end
  end

  always_comb begin
    o_alu_op   = '0;
    o_alu_in_0 = '0;
    o_alu_in_1 = '0;
    if (w_grant0) begin
      o_alu_op   = i_req0_op;
      o_alu_in_0 = i_req0_in_0;
      o_alu_in_1 = i_req0_in_1;
    end else if (w_grant1) begin
      o_alu_op   = i_req1_op;
      o_alu_in_0 = i_req1_in_0;
      o_alu_in_1 = i_req1_in_1;
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_rsp0_valid = r_rsp0Valid;
  assign o_rsp1_valid = r_rsp1Valid;
  assign o_rsp0_data  = r_rsp0Data;
  assign o_rsp1_data  = r_rsp1Data;

  // A new grant overrides a drain, so drain+accept keeps valid high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp0Valid <= 1'b0;
      r_rsp0Data  <= '0;
      r_rsp1Valid <= 1'b0;
      r_rsp1Data  <= '0;
    end else begin
      if (w_grant0) begin
        r_rsp0Valid <= 1'b1;
        r_rsp0Data  <= i_alu_out;
      end else if (i_rsp0_ready) begin
        r_rsp0Valid <= 1'b0;
      end
      if (w_grant1) begin
        r_rsp1Valid <= 1'b1;
        r_rsp1Data  <= i_alu_out;
      end else if (i_rsp1_ready) begin
        r_rsp1Valid <= 1'b0;
      end
    end
  end

  // r_lastGrant resets to port 1 so the first tie goes to port 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lastGrant <= 1'b1;
    end else if (w_grant0) begin
      r_lastGrant <= 1'b0;
    end else if (w_grant1) begin
      r_lastGrant <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_waitCnt <= '0;
    end else if (FIXED_PRIO == 0 || w_grant1 || !i_req1_valid) begin
      r_waitCnt <= '0;
    end else if (w_elig1 && r_waitCnt != MaxWait) begin
      r_waitCnt <= r_waitCnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// the same request stimulus, each driving its own small ALU model.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int O = 4;
  localparam logic [O-1:0] OpAdd = 4'd0;
  localparam logic [O-1:0] OpSub = 4'd1;
  localparam logic [O-1:0] OpXor = 4'd2;

  logic clk;
  logic rst_n;
  logic req0Valid, req1Valid, rsp0Ready, rsp1Ready;
  logic [O-1:0] req0Op, req1Op;
  logic [W-1:0] req0In0, req0In1, req1In0, req1In1;

  logic rrReq0Ready, rrReq1Ready, rrRsp0Valid, rrRsp1Valid;
  logic [W-1:0] rrRsp0Data, rrRsp1Data, rrAluIn0, rrAluIn1, rrAluOut;
  logic [O-1:0] rrAluOp;

  logic fpReq0Ready, fpReq1Ready, fpRsp0Valid, fpRsp1Valid;
  logic [W-1:0] fpRsp0Data, fpRsp1Data, fpAluIn0, fpAluIn1, fpAluOut;
  logic [O-1:0] fpAluOp;

  int checkCount = 0;
  int passCount  = 0;

  function automatic logic [W-1:0] aluModel(logic [O-1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpXor:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign rrAluOut = aluModel(rrAluOp, rrAluIn0, rrAluIn1);
  assign fpAluOut = aluModel(fpAluOp, fpAluIn0, fpAluIn1);

  alu_arbiter #(.WORD_WIDTH(W), .OP_WIDTH(O), .FIXED_PRIO(0), .MAX_WAIT(4)) dutRr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0Valid), .o_req0_ready(rrReq0Ready), .i_req0_op(req0Op),
    .i_req0_in_0(req0In0), .i_req0_in_1(req0In1),
    .o_rsp0_valid(rrRsp0Valid), .i_rsp0_ready(rsp0Ready), .o_rsp0_data(rrRsp0Data),
    .i_req1_valid(req1Valid), .o_req1_ready(rrReq1Ready), .i_req1_op(req1Op),
    .i_req1_in_0(req1In0), .i_req1_in_1(req1In1),
    .o_rsp1_valid(rrRsp1Valid), .i_rsp1_ready(rsp1Ready), .o_rsp1_data(rrRsp1Data),
    .o_alu_op(rrAluOp), .o_alu_in_0(rrAluIn0), .o_alu_in_1(rrAluIn1), .i_alu_out(rrAluOut)
  );

  alu_arbiter #(.WORD_WIDTH(W), .OP_WIDTH(O), .FIXED_PRIO(1), .MAX_WAIT(4)) dutFp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0Valid), .o_req0_ready(fpReq0Ready), .i_req0_op(req0Op),
    .i_req0_in_0(req0In0), .i_req0_in_1(req0In1),
    .o_rsp0_valid(fpRsp0Valid), .i_rsp0_ready(rsp0Ready), .o_rsp0_data(fpRsp0Data),
    .i_req1_valid(req1Valid), .o_req1_ready(fpReq1Ready), .i_req1_op(req1Op),
    .i_req1_in_0(req1In0), .i_req1_in_1(req1In1),
    .o_rsp1_valid(fpRsp1Valid), .i_rsp1_ready(rsp1Ready), .o_rsp1_data(fpRsp1Data),
    .o_alu_op(fpAluOp), .o_alu_in_0(fpAluIn0), .o_alu_in_1(fpAluIn1), .i_alu_out(fpAluOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later, before the next rising edge
  task automatic applyStimulus(input logic v0, input logic [O-1:0] op0, input logic [W-1:0] a0,
                               input logic [W-1:0] b0, input logic v1, input logic [O-1:0] op1,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic r0, input logic r1);
    @(negedge clk);
    req0Valid = v0; req0Op = op0; req0In0 = a0; req0In1 = b0;
    req1Valid = v1; req1Op = op1; req1In0 = a1; req1In1 = b1;
    rsp0Ready = r0; rsp1Ready = r1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0Valid = 0; req1Valid = 0; rsp0Ready = 0; rsp1Ready = 0;
    req0Op = '0; req1Op = '0; req0In0 = '0; req0In1 = '0; req1In0 = '0; req1In1 = '0;

    // Reset held with both ports requesting
    applyStimulus(1, OpAdd, 1, 2, 1, OpXor, 32'hF0, 32'h0F, 1, 1);
    checkOutput("rst ready0", rrReq0Ready, 0);
    checkOutput("rst ready1", rrReq1Ready, 0);
    checkOutput("rst rsp0 valid", rrRsp0Valid, 0);
    checkOutput("rst rsp1 valid", rrRsp1Valid, 0);
    checkOutput("rst alu op", rrAluOp, 0);
    checkOutput("rst alu in0", rrAluIn0, 0);
    checkOutput("rst rsp0 data", rrRsp0Data, 0);

    // Release: first tie goes to port 0 in both modes
    @(negedge clk); rst_n = 1'b1; #1;
    checkOutput("tie ready0", rrReq0Ready, 1);
    checkOutput("tie ready1", rrReq1Ready, 0);
    checkOutput("tie alu in0", rrAluIn0, 1);
    checkOutput("tie alu in1", rrAluIn1, 2);
    checkOutput("fp tie ready0", fpReq0Ready, 1);

    // Single port ADD 5,7
    applyStimulus(1, OpAdd, 5, 7, 0, OpAdd, 0, 0, 1, 1);
    checkOutput("single prev valid", rrRsp0Valid, 1);
    checkOutput("single prev data", rrRsp0Data, 3);
    checkOutput("single ready0", rrReq0Ready, 1);
    applyStimulus(0, OpAdd, 0, 0, 0, OpAdd, 0, 0, 1, 1);
    checkOutput("single valid T+1", rrRsp0Valid, 1);
    checkOutput("single data", rrRsp0Data, 12);
    checkOutput("single idle ready0", rrReq0Ready, 0);
    applyStimulus(0, OpAdd, 0, 0, 0, OpAdd, 0, 0, 1, 1);
    checkOutput("single drained", rrRsp0Valid, 0);
    checkOutput("single data kept", rrRsp0Data, 12);

    // Round-robin: last grant was port 0, so port 1 goes first
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, OpSub, 9, 4, 1, OpXor, 32'hF0, 32'h0F, 1, 1);
      checkOutput("rr ready1", rrReq1Ready, (i % 2 == 0) ? 1 : 0);
      checkOutput("rr ready0", rrReq0Ready, (i % 2 == 0) ? 0 : 1);
      if (i == 1) checkOutput("rr rsp1 data", rrRsp1Data, 32'hFF);
      if (i == 2) checkOutput("rr rsp0 data", rrRsp0Data, 5);
    end

    // Backpressure on port 0: port 1 takes every cycle, rsp0 held
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, OpSub, 9, 4, 1, OpAdd, 10 + i, 1, 0, 1);
      checkOutput("bp ready0", rrReq0Ready, 0);
      checkOutput("bp ready1", rrReq1Ready, 1);
      checkOutput("bp rsp0 valid", rrRsp0Valid, 1);
      checkOutput("bp rsp0 data", rrRsp0Data, 5);
      if (i > 0) checkOutput("bp rsp1 data", rrRsp1Data, 10 + i);
    end
    applyStimulus(1, OpAdd, 20, 22, 1, OpAdd, 0, 0, 1, 1);
    checkOutput("drain+acc ready0", rrReq0Ready, 1);
    checkOutput("drain+acc ready1", rrReq1Ready, 0);
    applyStimulus(0, OpAdd, 0, 0, 0, OpAdd, 0, 0, 0, 0);
    checkOutput("drain+acc valid", rrRsp0Valid, 1);
    checkOutput("drain+acc data", rrRsp0Data, 42);
    checkOutput("bp rsp1 drained", rrRsp1Valid, 0);
    checkOutput("bp rsp1 last", rrRsp1Data, 13);

    // Async reset between edges with a held port 1 result
    applyStimulus(0, OpAdd, 0, 0, 1, OpXor, 32'hF0, 32'h0F, 0, 0);
    checkOutput("pre-rst ready1", rrReq1Ready, 1);
    applyStimulus(0, OpAdd, 0, 0, 0, OpAdd, 0, 0, 0, 0);
    checkOutput("pre-rst rsp1 valid", rrRsp1Valid, 1);
    checkOutput("pre-rst rsp1 data", rrRsp1Data, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rsp1 valid", rrRsp1Valid, 0);
    checkOutput("async rsp1 data", rrRsp1Data, 0);
    checkOutput("async rsp0 valid", rrRsp0Valid, 0);

    // Release with both requesting: tie back to port 0, then starvation guard on fixed priority
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        req0Valid = 1; req0Op = OpSub; req0In0 = 9; req0In1 = 4;
        req1Valid = 1; req1Op = OpXor; req1In0 = 32'hF0; req1In1 = 32'h0F;
        rsp0Ready = 1; rsp1Ready = 1;
        #1;
        checkOutput("post-rst rr ready0", rrReq0Ready, 1);
      end else begin
        applyStimulus(1, OpSub, 9, 4, 1, OpXor, 32'hF0, 32'h0F, 1, 1);
      end
      checkOutput("fp ready1", fpReq1Ready, (i % 5 == 4) ? 1 : 0);
      checkOutput("fp ready0", fpReq0Ready, (i % 5 == 4) ? 0 : 1);
    end
    applyStimulus(0, OpAdd, 0, 0, 0, OpAdd, 0, 0, 0, 0);
    checkOutput("fp rsp1 valid", fpRsp1Valid, 1);
    checkOutput("fp rsp1 data", fpRsp1Data, 32'hFF);
    checkOutput("fp rsp0 data", fpRsp0Data, 5);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
